ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register. Consumes its registered control and data.
- Performs operand forwarding, ALU operations, branch compare and target calculation, and iterative multiply/divide into HI/LO.
- Drives the EX/MEM pipeline register. Asserts stall while a multiply/divide is running; the hazard unit then holds PC, IF/ID and ID/EX.

Parameters:
MD_ITERS, 32, multiply/divide iteration count. Only 32 is supported.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
EX_RegWrite / EX_MemRead / EX_MemWrite  in  1 each  control from ID/EX
EX_MemtoReg  in  2  0=ALU, 1=mem, 2=PC+4 (link)
EX_ALUSrc1  in  1  1: operand A = zero-extended EX_shamt
EX_ALUSrc2  in  1  1: operand B = EX_imm_ext
EX_Branch  in  1  branch instruction
EX_Branch_cmp_ctrl  in  3  0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez
EX_ALUOp  in  5  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra, 11 lui, 12 mult, 13 multu, 14 div, 15 divu, 16 mfhi, 17 mflo
EX_RegDst  in  2  0 rt, 1 rd, 2 $31
EX_ReadData1 / EX_ReadData2 / EX_imm_ext / EX_PCjia4  in  32 each  operands, immediate, PC+4
EX_shamt / EX_rt / EX_rd  in  5 each
fwd_a / fwd_b  in  2 each  0 register file, 1 MEM_fwd_data, 2 WB_fwd_data
MEM_fwd_data / WB_fwd_data  in  32 each
stall  out  1  hold upstream stages
branch_taken  out  1  combinational; redirect PC, flush IF/ID and ID/EX
branch_target  out  32  EX_PCjia4 + (EX_imm_ext << 2)
MEM_RegWrite / MEM_MemRead / MEM_MemWrite  out  1 each  registered
MEM_MemtoReg  out  2  registered
MEM_ALUResult / MEM_WriteData  out  32 each  registered; WriteData = forwarded B before the immediate mux
MEM_WriteReg  out  5  registered destination register

Behaviour:
- Reset: all MEM_* outputs are 0. HI and LO are 0. FSM is IDLE and counter is 0. The stall, branch_taken and branch_target outputs follow from this state.
- Reset mid-operation aborts the multiply/divide and leaves HI/LO at 0.
- Operands:
  - rs_val/rt_val come from the fwd_a/fwd_b mux. fwd value 3 is treated as 0.
  - A = ALUSrc1 ? shamt : rs_val. B = ALUSrc2 ? imm_ext : rt_val.
- ALU:
  - Shifts: amount is A[4:0], shifted value is rt_val. Variable shifts use ALUSrc1=0.
  - slt is signed; sltu is unsigned.
  - lui: B << 16.
  - Add/sub wrap; no overflow trap.
  - Undefined ALUOp: result 0.
  - MemtoReg=2 forces ALUResult = EX_PCjia4.
- Branch:
  - branch_taken = EX_Branch & cond, evaluated on forwarded rs_val/rt_val, signed compares against 0.
  - Forced 0 while stall=1.
- EX/MEM register:
  - Captures every cycle stall=0.
  - While stall=1, inserts a bubble: all control bits 0, data 0.
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE with ALUOp 12–15: latch operand magnitudes and signs, counter=0, go to BUSY. stall=1 this cycle.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle, counter+1. stall=1. After MD_ITERS steps, go to DONE.
  - DONE: write HI/LO with sign correction, stall=0, go to IDLE. EX/MEM captures the instruction normally; RegWrite is 0 from decode.
  - Total stall is 33 cycles per operation.
  - Sign rules: signed div truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend. Runs the full 32 cycles.
  - In DONE the held ID/EX still holds the same muldiv op. The FSM must not restart from that op; IDLE re-arms only after a cycle in which the op is no longer in EX.
- mfhi/mflo read the HI/LO registers. Back-to-back mult followed by mfhi returns the new value, because stall holds mfhi until DONE has written HI.

Test Plan:
- ALU/forwarding: rs_val=5, fwd_a=1 with MEM_fwd_data=0x10, B=imm 3, add -> MEM_ALUResult=0x13 on the next edge. sra rt=0x80000000, shamt 4 -> 0xF8000000.
- Branch: bne with rs=1, rt=2, imm=4, PC+4=0x100 -> branch_taken=1, branch_target=0x110 in the same cycle. beq on the same operands -> 0.
- mult -3 × 7 -> stall high for exactly 33 cycles and EX/MEM bubbles. Then HI=0xFFFFFFFF, LO=0xFFFFFFEB. A following mflo returns 0xFFFFFFEB.
- div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0 -> LO=0xFFFFFFFF, HI=7 after 33 stall cycles.
- Drop reset_n to 0 at BUSY cycle 10 -> all outputs 0 and stall=0 immediately (asynchronous), HI=LO=0. After release, a new mult completes correctly.
- jal path: MemtoReg=2, RegDst=2, PC+4=0x40 -> MEM_ALUResult=0x40, MEM_WriteReg=31.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs and EX/MEM outputs around the execute stage.
// The stage itself uses the slave view; the driving pipeline side uses master.
interface ex_stage_if;
  logic        EX_RegWrite;
  logic        EX_MemRead;
  logic        EX_MemWrite;
  logic [1:0]  EX_MemtoReg;
  logic        EX_ALUSrc1;
  logic        EX_ALUSrc2;
  logic        EX_Branch;
  logic [2:0]  EX_Branch_cmp_ctrl;
  logic [4:0]  EX_ALUOp;
  logic [1:0]  EX_RegDst;
  logic [31:0] EX_ReadData1;
  logic [31:0] EX_ReadData2;
  logic [31:0] EX_imm_ext;
  logic [31:0] EX_PCjia4;
  logic [4:0]  EX_shamt;
  logic [4:0]  EX_rt;
  logic [4:0]  EX_rd;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] MEM_fwd_data;
  logic [31:0] WB_fwd_data;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        MEM_RegWrite;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [1:0]  MEM_MemtoReg;
  logic [31:0] MEM_ALUResult;
  logic [31:0] MEM_WriteData;
  logic [4:0]  MEM_WriteReg;

  modport slave (
    input  EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc1, EX_ALUSrc2,
           EX_Branch, EX_Branch_cmp_ctrl, EX_ALUOp, EX_RegDst, EX_ReadData1, EX_ReadData2,
           EX_imm_ext, EX_PCjia4, EX_shamt, EX_rt, EX_rd, fwd_a, fwd_b,
           MEM_fwd_data, WB_fwd_data,
    output stall, branch_taken, branch_target, MEM_RegWrite, MEM_MemRead, MEM_MemWrite,
           MEM_MemtoReg, MEM_ALUResult, MEM_WriteData, MEM_WriteReg
  );

  modport master (
    output EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc1, EX_ALUSrc2,
           EX_Branch, EX_Branch_cmp_ctrl, EX_ALUOp, EX_RegDst, EX_ReadData1, EX_ReadData2,
           EX_imm_ext, EX_PCjia4, EX_shamt, EX_rt, EX_rd, fwd_a, fwd_b,
           MEM_fwd_data, WB_fwd_data,
    input  stall, branch_taken, branch_target, MEM_RegWrite, MEM_MemRead, MEM_MemWrite,
           MEM_MemtoReg, MEM_ALUResult, MEM_WriteData, MEM_WriteReg
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolve, iterative mult/div into HI/LO,
// and the EX/MEM pipeline register.
module ex_stage #(
  parameter int MD_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  ex_stage_if.slave   bus
);
  localparam int CNT_W = $clog2(MD_ITERS) + 1;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              armed_reg, armed_next;
  logic [31:0]       md_hi_reg, md_lo_reg, md_b_reg;
  logic              md_div_reg, md_neg_q_reg, md_neg_r_reg, md_divz_reg;
  logic [31:0]       hi_reg, lo_reg;

  logic [31:0] rs_val, rt_val, op_a, op_b, alu_result, ex_result;
  logic        is_md_op, md_signed, md_is_div, md_start, md_last;
  logic        br_cond;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_rem_sh;
  logic        div_ok;
  logic [31:0] step_hi, step_lo;
  logic [63:0] md_prod, md_prod_fix;
  logic [31:0] hi_fin, lo_fin;
  logic [4:0]  write_reg;

  // Operand forwarding; selector value 3 is unused and yields zero.
  always_comb begin
    rs_val = 32'd0;
    case (bus.fwd_a)
      2'd0: rs_val = bus.EX_ReadData1;
      2'd1: rs_val = bus.MEM_fwd_data;
      2'd2: rs_val = bus.WB_fwd_data;
      default: rs_val = 32'd0;
    endcase
    rt_val = 32'd0;
    case (bus.fwd_b)
      2'd0: rt_val = bus.EX_ReadData2;
      2'd1: rt_val = bus.MEM_fwd_data;
      2'd2: rt_val = bus.WB_fwd_data;
      default: rt_val = 32'd0;
    endcase
  end

  assign op_a = bus.EX_ALUSrc1 ? {27'd0, bus.EX_shamt} : rs_val;
  assign op_b = bus.EX_ALUSrc2 ? bus.EX_imm_ext : rt_val;

  always_comb begin
    alu_result = 32'd0;
    case (bus.EX_ALUOp)
      5'd0:  alu_result = op_a + op_b;
      5'd1:  alu_result = op_a - op_b;
      5'd2:  alu_result = op_a & op_b;
      5'd3:  alu_result = op_a | op_b;
      5'd4:  alu_result = op_a ^ op_b;
      5'd5:  alu_result = ~(op_a | op_b);
      5'd6:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      5'd7:  alu_result = {31'd0, op_a < op_b};
      5'd8:  alu_result = rt_val << op_a[4:0];
      5'd9:  alu_result = rt_val >> op_a[4:0];
      5'd10: alu_result = $unsigned($signed(rt_val) >>> op_a[4:0]);
      5'd11: alu_result = op_b << 16;
      5'd16: alu_result = hi_reg;
      5'd17: alu_result = lo_reg;
      default: alu_result = 32'd0;
    endcase
  end

  assign ex_result = (bus.EX_MemtoReg == 2'd2) ? bus.EX_PCjia4 : alu_result;

  always_comb begin
    br_cond = 1'b0;
    case (bus.EX_Branch_cmp_ctrl)
      3'd0: br_cond = (rs_val == rt_val);
      3'd1: br_cond = (rs_val != rt_val);
      3'd2: br_cond = ($signed(rs_val) <= 0);
      3'd3: br_cond = ($signed(rs_val) > 0);
      3'd4: br_cond = rs_val[31];
      3'd5: br_cond = ~rs_val[31];
      default: br_cond = 1'b0;
    endcase
  end

  assign bus.branch_taken  = bus.EX_Branch & br_cond & ~bus.stall;
  assign bus.branch_target = bus.EX_PCjia4 + (bus.EX_imm_ext << 2);

  assign is_md_op  = (bus.EX_ALUOp >= 5'd12) && (bus.EX_ALUOp <= 5'd15);
  assign md_is_div = bus.EX_ALUOp[1];
  assign md_signed = ~bus.EX_ALUOp[0];
  assign mag_a = (md_signed & rs_val[31]) ? -rs_val : rs_val;
  assign mag_b = (md_signed & rt_val[31]) ? -rt_val : rt_val;
  assign md_last = (cnt_reg == CNT_W'(MD_ITERS - 1));

  // FSM state register. armed_reg resets low so an op aborted by reset is not
  // replayed; a non-muldiv cycle in EX re-arms the unit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= MD_IDLE;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= armed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    armed_next = armed_reg;
    case (state_reg)
      MD_IDLE: begin
        if (md_start) state_next = MD_BUSY;
        if (!is_md_op) armed_next = 1'b1;
      end
      MD_BUSY: if (md_last) state_next = MD_DONE;
      MD_DONE: begin
        state_next = MD_IDLE;
        armed_next = 1'b0;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    md_start  = (state_reg == MD_IDLE) && is_md_op && armed_reg;
    bus.stall = md_start || (state_reg == MD_BUSY);
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  assign mul_sum    = {1'b0, md_hi_reg} + (md_lo_reg[0] ? {1'b0, md_b_reg} : 33'd0);
  assign div_rem_sh = {md_hi_reg, md_lo_reg[31]};
  assign div_ok     = (div_rem_sh >= {1'b0, md_b_reg});
  assign step_hi = md_div_reg ? (div_ok ? div_rem_sh[31:0] - md_b_reg : div_rem_sh[31:0])
                              : mul_sum[32:1];
  assign step_lo = md_div_reg ? {md_lo_reg[30:0], div_ok} : {mul_sum[0], md_lo_reg[31:1]};

  assign md_prod     = {md_hi_reg, md_lo_reg};
  assign md_prod_fix = md_neg_q_reg ? -md_prod : md_prod;

  always_comb begin
    hi_fin = md_prod_fix[63:32];
    lo_fin = md_prod_fix[31:0];
    if (md_div_reg) begin
      hi_fin = md_neg_r_reg ? -md_hi_reg : md_hi_reg;
      lo_fin = md_divz_reg ? 32'hFFFF_FFFF : (md_neg_q_reg ? -md_lo_reg : md_lo_reg);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      md_hi_reg    <= 32'd0;
      md_lo_reg    <= 32'd0;
      md_b_reg     <= 32'd0;
      md_div_reg   <= 1'b0;
      md_neg_q_reg <= 1'b0;
      md_neg_r_reg <= 1'b0;
      md_divz_reg  <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
    end else begin
      case (state_reg)
        MD_IDLE: if (md_start) begin
          cnt_reg      <= '0;
          md_hi_reg    <= 32'd0;
          md_lo_reg    <= mag_a;
          md_b_reg     <= mag_b;
          md_div_reg   <= md_is_div;
          md_neg_q_reg <= md_signed & (rs_val[31] ^ rt_val[31]) & ~(md_is_div & (rt_val == 32'd0));
          md_neg_r_reg <= md_signed & rs_val[31];
          md_divz_reg  <= md_is_div & (rt_val == 32'd0);
        end
        MD_BUSY: begin
          md_hi_reg <= step_hi;
          md_lo_reg <= step_lo;
          cnt_reg   <= cnt_reg + CNT_W'(1);
        end
        MD_DONE: begin
          hi_reg <= hi_fin;
          lo_reg <= lo_fin;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    write_reg = 5'd0;
    case (bus.EX_RegDst)
      2'd0: write_reg = bus.EX_rt;
      2'd1: write_reg = bus.EX_rd;
      2'd2: write_reg = 5'd31;
      default: write_reg = 5'd0;
    endcase
  end

  // EX/MEM register; a stalled cycle is sent downstream as a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || bus.stall) begin
      bus.MEM_RegWrite  <= 1'b0;
      bus.MEM_MemRead   <= 1'b0;
      bus.MEM_MemWrite  <= 1'b0;
      bus.MEM_MemtoReg  <= 2'd0;
      bus.MEM_ALUResult <= 32'd0;
      bus.MEM_WriteData <= 32'd0;
      bus.MEM_WriteReg  <= 5'd0;
    end else begin
      bus.MEM_RegWrite  <= bus.EX_RegWrite;
      bus.MEM_MemRead   <= bus.EX_MemRead;
      bus.MEM_MemWrite  <= bus.EX_MemWrite;
      bus.MEM_MemtoReg  <= bus.EX_MemtoReg;
      bus.MEM_ALUResult <= ex_result;
      bus.MEM_WriteData <= rt_val;
      bus.MEM_WriteReg  <= write_reg;
    end
  end
endmodule
